operand_fetch: RTL and testbench

Operand-fetch stage directly upstream of the ALU. Accepts 32-bit instruction words from fetch, decodes them, reads the 8×32 register file, and presents a registered operand bundle (reg_a_data, reg_b_data, immediate, opcode, addressing_mode) to the ALU under a valid/ready handshake. Owns the architectural register file and its writeback port. Stalls on read-after-write hazards using a pending-write scoreboard.

---
 rtl/mp_pkg.sv | 76 +++++++
 rtl/regfile_8x32.sv | 52 +++++
 rtl/operand_fetch.sv | 128 ++++++++++++
 tb/tb_operand_fetch.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp_pkg.sv
// mp_pkg
// Shared definitions for the operand-fetch stage and its neighbours.
// Holds the opcode encodings (same values the ALU decodes), the bit
// positions of every instruction field, the register-file geometry,
// the packed views of an instruction word and of the operand bundle,
// and the decode helpers that say which registers an opcode touches.
package mp_pkg;

  localparam int NUM_REGS  = 8;
  localparam int REG_IDX_W = $clog2(NUM_REGS);
  localparam int DATA_W    = 32;
  localparam int INSTR_W   = 32;
  localparam int IMM_W     = 21;
  localparam int OPCODE_W  = 4;

  localparam logic [OPCODE_W-1:0] OP_ADD = 4'b0010;
  localparam logic [OPCODE_W-1:0] OP_SUB = 4'b0011;
  localparam logic [OPCODE_W-1:0] OP_MOV = 4'b0100;
  localparam logic [OPCODE_W-1:0] OP_AND = 4'b1000;
  localparam logic [OPCODE_W-1:0] OP_ORR = 4'b1001;
  localparam logic [OPCODE_W-1:0] OP_EOR = 4'b1010;
  localparam logic [OPCODE_W-1:0] OP_MVN = 4'b1011;
  localparam logic [OPCODE_W-1:0] OP_LSL = 4'b1100;
  localparam logic [OPCODE_W-1:0] OP_LSR = 4'b1101;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 28;
  localparam int MODE_BIT   = 27;
  localparam int RD_MSB     = 26;
  localparam int RD_LSB     = 24;
  localparam int RN_MSB     = 23;
  localparam int RN_LSB     = 21;
  localparam int IMM_MSB    = 20;
  localparam int IMM_LSB    = 0;
  localparam int RM_MSB     = 2;
  localparam int RM_LSB     = 0;

  // Packed view of an instruction word; member order follows the field
  // positions above so a plain cast splits the word correctly.
  typedef struct packed {
    logic [OPCODE_W-1:0]  opcode;
    logic                 mode;
    logic [REG_IDX_W-1:0] rd;
    logic [REG_IDX_W-1:0] rn;
    logic [IMM_W-1:0]     imm;
  } instr_t;

  // Everything the ALU sees alongside out_valid.
  typedef struct packed {
    logic [DATA_W-1:0]    regA;
    logic [DATA_W-1:0]    regB;
    logic [IMM_W-1:0]     imm;
    logic [OPCODE_W-1:0]  opcode;
    logic                 mode;
    logic [REG_IDX_W-1:0] rd;
    logic                 writesRd;
  } bundle_t;

  // Opcodes that produce a result in rd.
  function automatic logic writesRdOf(input logic [OPCODE_W-1:0] op);
    logic result;
    result = 1'b0;
    case (op)
      OP_MOV, OP_MVN, OP_AND, OP_ORR, OP_EOR,
      OP_LSL, OP_LSR, OP_ADD, OP_SUB: result = 1'b1;
      default:                        result = 1'b0;
    endcase
    return result;
  endfunction

  // MOV and MVN take only op2, so rn is a don't-care for them.
  function automatic logic usesRnOf(input logic [OPCODE_W-1:0] op);
    return !((op == OP_MOV) || (op == OP_MVN));
  endfunction

endpackage

// File: rtl/regfile_8x32.sv
// regfile_8x32
// Architectural register file: NUM_REGS x DATA_W, two asynchronous read
// ports and one synchronous write port. A read of the register being
// written in the same cycle returns the incoming write data, so a
// consumer can pick up a writeback without waiting a cycle.
// Ports:
//   clk, rst             clock, synchronous active-high reset (clears all)
//   rdAddrA_i/rdDataA_o  read port A
//   rdAddrB_i/rdDataB_o  read port B
//   wrEn_i, wrAddr_i, wrData_i  write port
module regfile_8x32
  import mp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] rdAddrA_i,
  output logic [DATA_W-1:0]    rdDataA_o,
  input  logic [REG_IDX_W-1:0] rdAddrB_i,
  output logic [DATA_W-1:0]    rdDataB_o,
  input  logic                 wrEn_i,
  input  logic [REG_IDX_W-1:0] wrAddr_i,
  input  logic [DATA_W-1:0]    wrData_i
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wrEn_i) begin
      mem_q[wrAddr_i] <= wrData_i;
    end
  end

  // Write-to-read bypass on both ports.
  always_comb begin
    rdDataA_o = mem_q[rdAddrA_i];
    if (wrEn_i && (wrAddr_i == rdAddrA_i)) begin
      rdDataA_o = wrData_i;
    end
  end

  always_comb begin
    rdDataB_o = mem_q[rdAddrB_i];
    if (wrEn_i && (wrAddr_i == rdAddrB_i)) begin
      rdDataB_o = wrData_i;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch
// Decodes instruction words from fetch, reads rn/rm from the register
// file and hands a registered operand bundle to the ALU under a
// valid/ready handshake. A pending-write scoreboard holds back any
// instruction whose source register still awaits its writeback.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid/in_ready/in_instr   instruction input handshake
//   out_valid/out_ready          operand bundle handshake
//   reg_a_data, reg_b_data, immediate, opcode, addressing_mode, rd,
//   writes_rd                    registered operand bundle
//   wb_en, wb_addr, wb_data      register-file writeback port
module operand_fetch
  import mp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSTR_W-1:0]   in_instr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    reg_a_data,
  output logic [DATA_W-1:0]    reg_b_data,
  output logic [IMM_W-1:0]     immediate,
  output logic [OPCODE_W-1:0]  opcode,
  output logic                 addressing_mode,
  output logic [REG_IDX_W-1:0] rd,
  output logic                 writes_rd,
  input  logic                 wb_en,
  input  logic [REG_IDX_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]    wb_data
);

  instr_t               instr;
  logic [REG_IDX_W-1:0] rmIdx;
  logic                 useRn;
  logic                 useRm;
  logic [DATA_W-1:0]    rnData;
  logic [DATA_W-1:0]    rmData;
  logic [NUM_REGS-1:0]  wbMask;
  logic [NUM_REGS-1:0]  livePending;
  logic                 hazard;
  logic                 canAccept;
  logic                 issue;

  logic [NUM_REGS-1:0]  pending_q, pending_d;
  logic                 outValid_q, outValid_d;
  bundle_t              bundle_q, bundle_d;

  assign instr = instr_t'(in_instr);
  assign rmIdx = instr.imm[RM_MSB:RM_LSB];
  assign useRn = usesRnOf(instr.opcode);
  assign useRm = instr.mode;

  regfile_8x32 u_regfile (
    .clk       (clk),
    .rst       (rst),
    .rdAddrA_i (instr.rn),
    .rdDataA_o (rnData),
    .rdAddrB_i (rmIdx),
    .rdDataB_o (rmData),
    .wrEn_i    (wb_en),
    .wrAddr_i  (wb_addr),
    .wrData_i  (wb_data)
  );

  always_comb begin
    wbMask = '0;
    if (wb_en) begin
      wbMask[wb_addr] = 1'b1;
    end
  end

  // A writeback landing this cycle already satisfies its reader through
  // the register-file bypass, so it is masked out before the hazard test.
  assign livePending = pending_q & ~wbMask;
  assign hazard      = (useRn && livePending[instr.rn]) ||
                       (useRm && livePending[rmIdx]);
  assign canAccept   = !outValid_q || out_ready;
  assign in_ready    = canAccept && !(in_valid && hazard);
  assign issue       = in_valid && in_ready;

  // Next-state for the scoreboard and output register. Issue sets the
  // pending bit after the writeback clear so that set wins a collision.
  always_comb begin
    pending_d  = pending_q & ~wbMask;
    outValid_d = outValid_q;
    bundle_d   = bundle_q;
    if (issue) begin
      outValid_d        = 1'b1;
      bundle_d.regA     = rnData;
      bundle_d.regB     = instr.mode ? rmData : '0;
      bundle_d.imm      = instr.imm;
      bundle_d.opcode   = instr.opcode;
      bundle_d.mode     = instr.mode;
      bundle_d.rd       = instr.rd;
      bundle_d.writesRd = writesRdOf(instr.opcode);
      if (writesRdOf(instr.opcode)) begin
        pending_d[instr.rd] = 1'b1;
      end
    end else if (out_ready) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      outValid_q <= 1'b0;
      bundle_q   <= '0;
    end else begin
      pending_q  <= pending_d;
      outValid_q <= outValid_d;
      bundle_q   <= bundle_d;
    end
  end

  assign out_valid       = outValid_q;
  assign reg_a_data      = bundle_q.regA;
  assign reg_b_data      = bundle_q.regB;
  assign immediate       = bundle_q.imm;
  assign opcode          = bundle_q.opcode;
  assign addressing_mode = bundle_q.mode;
  assign rd              = bundle_q.rd;
  assign writes_rd       = bundle_q.writesRd;

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch
// Directed scenarios plus a randomized run of operand_fetch, checked
// against a behavioural model of the register file, pending-write set and
// output bundle kept in plain arrays.
module tb_operand_fetch;

  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [3:0] SUB = 4'b0011;
  localparam logic [3:0] MOV = 4'b0100;
  localparam logic [3:0] ANDOP = 4'b1000;
  localparam logic [3:0] ORR = 4'b1001;
  localparam logic [3:0] EOR = 4'b1010;
  localparam logic [3:0] MVN = 4'b1011;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] reg_a_data;
  logic [31:0] reg_b_data;
  logic [20:0] immediate;
  logic [3:0]  opcode;
  logic        addressing_mode;
  logic [2:0]  rd;
  logic        writes_rd;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [31:0] wb_data;

  int errors = 0;
  int checks = 0;

  // Behavioural model state.
  logic [31:0] mRegs [8];
  bit          mPend [8];
  logic        mOutValid;
  logic [31:0] mA;
  logic [31:0] mB;
  logic [20:0] mImm;
  logic [3:0]  mOp;
  logic        mMode;
  logic [2:0]  mRd;
  logic        mWr;
  logic        expInReady;
  logic        obsInReady;
  bit          lastIssued;

  logic [94:0] obsBundle;
  assign obsBundle = {out_valid, reg_a_data, reg_b_data, immediate,
                      opcode, addressing_mode, rd, writes_rd};

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_instr        (in_instr),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .reg_a_data      (reg_a_data),
    .reg_b_data      (reg_b_data),
    .immediate       (immediate),
    .opcode          (opcode),
    .addressing_mode (addressing_mode),
    .rd              (rd),
    .writes_rd       (writes_rd),
    .wb_en           (wb_en),
    .wb_addr         (wb_addr),
    .wb_data         (wb_data)
  );

  // Guards against a hung run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] mk(input logic [3:0] op, input logic mode,
                                     input int d, input int n, input int imm);
    logic [2:0]  dd;
    logic [2:0]  nn;
    logic [20:0] ii;
    dd = d[2:0];
    nn = n[2:0];
    ii = imm[20:0];
    return {op, mode, dd, nn, ii};
  endfunction

  function automatic bit isWriter(input logic [3:0] op);
    return op inside {MOV, MVN, ANDOP, ORR, EOR, 4'b1100, 4'b1101, ADD, SUB};
  endfunction

  function automatic bit readsRn(input logic [3:0] op);
    return !(op == MOV || op == MVN);
  endfunction

  function automatic logic [31:0] mRead(input int s);
    if (wb_en && wb_addr == s[2:0]) return wb_data;
    return mRegs[s];
  endfunction

  function automatic logic [94:0] expBundle();
    return {mOutValid, mA, mB, mImm, mOp, mMode, mRd, mWr};
  endfunction

  // Advances one clock: samples in_ready before the edge, predicts it
  // from the model, then applies the edge to the model.
  task automatic applyStimulus();
    bit   hz;
    logic [3:0] op;
    int   rn;
    int   rm;
    int   dI;
    @(negedge clk);
    obsInReady = in_ready;
    op = in_instr[31:28];
    rn = int'(in_instr[23:21]);
    rm = int'(in_instr[2:0]);
    dI = int'(in_instr[26:24]);
    hz = 1'b0;
    if (readsRn(op) && mPend[rn] && !(wb_en && wb_addr == rn[2:0])) hz = 1'b1;
    if (in_instr[27] && mPend[rm] && !(wb_en && wb_addr == rm[2:0])) hz = 1'b1;
    expInReady = (!mOutValid || out_ready) && !(in_valid && hz);
    lastIssued = in_valid && expInReady;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        mRegs[i] = '0;
        mPend[i] = 1'b0;
      end
      {mOutValid, mA, mB, mImm, mOp, mMode, mRd, mWr} = '0;
    end else begin
      if (lastIssued) begin
        mA        = mRead(rn);
        mB        = in_instr[27] ? mRead(rm) : 32'd0;
        mImm      = in_instr[20:0];
        mOp       = op;
        mMode     = in_instr[27];
        mRd       = in_instr[26:24];
        mWr       = isWriter(op);
        mOutValid = 1'b1;
      end else if (out_ready) begin
        mOutValid = 1'b0;
      end
      if (wb_en) begin
        mPend[wb_addr] = 1'b0;
        mRegs[wb_addr] = wb_data;
      end
      if (lastIssued && isWriter(op)) mPend[dI] = 1'b1;
    end
    #1;
  endtask

  task automatic idleInputs();
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    out_ready = 1'b1;
    wb_en     = 1'b0;
    wb_addr   = '0;
    wb_data   = '0;
  endtask

  task automatic doReset();
    idleInputs();
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idleInputs();
    in_valid = 1'b1;
    in_instr = mk(ADD, 1, 3, 1, 2);
    rst = 1'b1;
    applyStimulus();
    checks++;
    if (obsBundle !== 95'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h want 0", obsBundle);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    applyStimulus();
    checks++;
    if (obsInReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %b want 1", obsInReady);
    end
  endtask

  task automatic test_add_basic();
    doReset();
    wb_en = 1'b1; wb_addr = 3'd1; wb_data = 32'd5;
    applyStimulus();
    wb_addr = 3'd2; wb_data = 32'd7;
    applyStimulus();
    wb_en = 1'b0;
    in_valid = 1'b1;
    in_instr = mk(ADD, 1, 3, 1, 2);
    applyStimulus();
    in_valid = 1'b0;
    checks++;
    if (obsInReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL add_in_ready: got %b want 1", obsInReady);
    end
    checks++;
    if (!(out_valid === 1'b1 && reg_a_data === 32'd5 && reg_b_data === 32'd7 &&
          opcode === ADD && rd === 3'd3 && writes_rd === 1'b1)) begin
      errors++;
      $display("[TB] FAIL add_bundle: got v=%b a=%h b=%h op=%h rd=%0d w=%b want v=1 a=5 b=7 op=2 rd=3 w=1",
               out_valid, reg_a_data, reg_b_data, opcode, rd, writes_rd);
    end
    applyStimulus();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL add_drain: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_raw_stall();
    doReset();
    in_valid = 1'b1;
    in_instr = mk(MOV, 0, 4, 0, 21'h1FFFFF);
    applyStimulus();
    in_instr = mk(ADD, 0, 5, 4, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checks++;
      if (obsInReady !== 1'b0) begin
        errors++;
        $display("[TB] FAIL raw_stall_%0d: got in_ready=%b want 0", i, obsInReady);
      end
    end
    wb_en = 1'b1; wb_addr = 3'd4; wb_data = 32'h001FFFFF;
    applyStimulus();
    wb_en = 1'b0; in_valid = 1'b0;
    checks++;
    if (obsInReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL raw_release: got in_ready=%b want 1", obsInReady);
    end
    checks++;
    if (!(out_valid === 1'b1 && reg_a_data === 32'h001FFFFF && rd === 3'd5)) begin
      errors++;
      $display("[TB] FAIL raw_bypass: got v=%b a=%h rd=%0d want v=1 a=001fffff rd=5",
               out_valid, reg_a_data, rd);
    end
    checks++;
    if (obsBundle !== expBundle()) begin
      errors++;
      $display("[TB] FAIL raw_model: got %h want %h", obsBundle, expBundle());
    end
  endtask

  task automatic test_backpressure();
    doReset();
    in_valid = 1'b1;
    in_instr = mk(ADD, 0, 1, 0, 3);
    applyStimulus();
    out_ready = 1'b0;
    in_instr = mk(ORR, 0, 2, 0, 5);
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checks++;
      if (!(obsInReady === 1'b0 && out_valid === 1'b1 && immediate === 21'd3 &&
            opcode === ADD && rd === 3'd1)) begin
        errors++;
        $display("[TB] FAIL hold_%0d: got rdy=%b v=%b imm=%h op=%h rd=%0d want rdy=0 v=1 imm=3 op=2 rd=1",
                 i, obsInReady, out_valid, immediate, opcode, rd);
      end
    end
    out_ready = 1'b1;
    applyStimulus();
    in_valid = 1'b0;
    checks++;
    if (!(obsInReady === 1'b1 && out_valid === 1'b1 && immediate === 21'd5 &&
          opcode === ORR && rd === 3'd2)) begin
      errors++;
      $display("[TB] FAIL release: got rdy=%b v=%b imm=%h op=%h rd=%0d want rdy=1 v=1 imm=5 op=9 rd=2",
               obsInReady, out_valid, immediate, opcode, rd);
    end
  endtask

  task automatic test_wb_set_collide();
    doReset();
    in_valid = 1'b1;
    in_instr = mk(ADD, 0, 2, 0, 1);
    applyStimulus();
    in_instr = mk(SUB, 0, 2, 0, 2);
    wb_en = 1'b1; wb_addr = 3'd2; wb_data = 32'd9;
    applyStimulus();
    checks++;
    if (obsInReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL collide_issue: got in_ready=%b want 1", obsInReady);
    end
    wb_en = 1'b0;
    in_instr = mk(EOR, 0, 7, 2, 0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus();
      checks++;
      if (obsInReady !== 1'b0) begin
        errors++;
        $display("[TB] FAIL collide_stall_%0d: got in_ready=%b want 0", i, obsInReady);
      end
    end
    wb_en = 1'b1; wb_addr = 3'd2; wb_data = 32'h77;
    applyStimulus();
    wb_en = 1'b0; in_valid = 1'b0;
    checks++;
    if (!(obsInReady === 1'b1 && reg_a_data === 32'h77 && rd === 3'd7)) begin
      errors++;
      $display("[TB] FAIL collide_release: got rdy=%b a=%h rd=%0d want rdy=1 a=77 rd=7",
               obsInReady, reg_a_data, rd);
    end
  endtask

  task automatic test_mvn_no_stall();
    doReset();
    in_valid = 1'b1;
    in_instr = mk(ADD, 0, 0, 1, 0);
    applyStimulus();
    in_instr = mk(MVN, 0, 6, 0, 0);
    applyStimulus();
    in_valid = 1'b0;
    checks++;
    if (!(obsInReady === 1'b1 && out_valid === 1'b1 && opcode === MVN && rd === 3'd6)) begin
      errors++;
      $display("[TB] FAIL mvn: got rdy=%b v=%b op=%h rd=%0d want rdy=1 v=1 op=b rd=6",
               obsInReady, out_valid, opcode, rd);
    end
  endtask

  task automatic test_reset_mid();
    doReset();
    in_valid = 1'b1;
    in_instr = mk(ADD, 0, 2, 0, 1);
    applyStimulus();
    in_instr = mk(ADD, 0, 3, 0, 1);
    out_ready = 1'b0;
    applyStimulus();
    in_valid = 1'b0;
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    checks++;
    if (obsBundle !== 95'd0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got %h want 0", obsBundle);
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_instr = mk(ADD, 1, 4, 2, 3);
    wb_en = 1'b1; wb_addr = 3'd2; wb_data = 32'h55;
    applyStimulus();
    wb_en = 1'b0;
    checks++;
    if (!(obsInReady === 1'b1 && reg_a_data === 32'h55 && reg_b_data === 32'd0)) begin
      errors++;
      $display("[TB] FAIL midreset_reader: got rdy=%b a=%h b=%h want rdy=1 a=55 b=0",
               obsInReady, reg_a_data, reg_b_data);
    end
    in_instr = mk(ANDOP, 0, 1, 2, 0);
    applyStimulus();
    in_valid = 1'b0;
    checks++;
    if (!(obsInReady === 1'b1 && reg_a_data === 32'h55)) begin
      errors++;
      $display("[TB] FAIL midreset_wb_kept: got rdy=%b a=%h want rdy=1 a=55",
               obsInReady, reg_a_data);
    end
  endtask

  task automatic test_random();
    int pendList[$];
    doReset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!in_valid || lastIssued) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_instr = $urandom;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      wb_en     = $urandom_range(0, 1);
      wb_data   = $urandom;
      pendList.delete();
      for (int r = 0; r < 8; r++) if (mPend[r]) pendList.push_back(r);
      if (pendList.size() != 0 && $urandom_range(0, 3) != 0)
        wb_addr = 3'(pendList[$urandom_range(0, pendList.size() - 1)]);
      else
        wb_addr = 3'($urandom_range(0, 7));
      applyStimulus();
      checks++;
      if (obsInReady !== expInReady) begin
        errors++;
        $display("[TB] FAIL rand_in_ready@%0d: got %b want %b", cyc, obsInReady, expInReady);
      end
      checks++;
      if (obsBundle !== expBundle()) begin
        errors++;
        $display("[TB] FAIL rand_bundle@%0d: got %h want %h", cyc, obsBundle, expBundle());
      end
    end
    idleInputs();
  endtask

  initial begin
    idleInputs();
    lastIssued = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mRegs[i] = '0;
      mPend[i] = 1'b0;
    end
    {mOutValid, mA, mB, mImm, mOp, mMode, mRd, mWr} = '0;
    test_reset();
    test_add_basic();
    test_raw_stall();
    test_backpressure();
    test_wb_set_collide();
    test_mvn_no_stall();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
